// File: rtl/sram_map_pkg.sv
// Address map and shared helpers for the data-SRAM responder: config window
// base, register offsets, read-select encoding and byte-lane merging.
package sram_map_pkg;

  localparam logic [31:0] CONF_BASE_DEFAULT = 32'hbfaf_0000;

  localparam logic [15:0] CONF_LED    = 16'hf000;
  localparam logic [15:0] CONF_NUM    = 16'hf010;
  localparam logic [15:0] CONF_SWITCH = 16'hf020;
  localparam logic [15:0] CONF_TIMER  = 16'he000;

  // Which source drives data_sram_rdata, captured with each read.
  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_CONF = 1'b1
  } rd_sel_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bytewrite_ram.sv
// Single-port byte-writable RAM, one-cycle registered read, read output
// holds its previous value on write and idle cycles.
module bytewrite_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // NOTE: the array has no reset on purpose; resetting a memory forces it out
  // of block RAM into flops, and software never relies on its power-up value.
  logic [31:0] mem [2**AW];

  // NOTE: every register here uses <=, so a read in the cycle after a write
  // sees the stored word with no ordering hazard between procedural blocks.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen == 4'b0000) begin
        rdata <= mem[addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM port responder: byte-writable RAM plus a config window holding
// LED, number display, synchronized switches and a free-running timer.
module data_sram_responder
  import sram_map_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  input  logic [7:0]  switch
);

  logic        is_conf;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] conf_off;
  logic        ram_en;
  logic [31:0] ram_rdata;

  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] timer_q;
  logic [31:0] timer_inc;
  logic [31:0] timer_next;

  logic [31:0] conf_rdata;
  logic [31:0] conf_rdata_q;
  rd_sel_e     rd_sel_q;

  logic        unused_addr_lsbs;

  assign is_conf  = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign rd_req   = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr_req   = data_sram_en && (data_sram_wen != 4'b0000);
  assign conf_off = {data_sram_addr[15:2], 2'b00};

  assign unused_addr_lsbs = ^data_sram_addr[1:0];

  // The RAM has no reset, so an access overlapping reset is blocked here.
  assign ram_en = data_sram_en && !is_conf && !reset;

  bytewrite_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .wen  (data_sram_wen),
    .addr (data_sram_addr[RAM_AW+1:2]),
    .wdata(data_sram_wdata),
    .rdata(ram_rdata)
  );

  assign timer_inc  = timer_q + 32'd1;
  assign timer_next = (wr_req && is_conf && conf_off == CONF_TIMER)
                    ? merge_lanes(timer_inc, data_sram_wdata, data_sram_wen)
                    : timer_inc;

  // NOTE: the default before the case keeps this purely combinational; an
  // offset that assigned nothing would otherwise infer a latch.
  always_comb begin
    conf_rdata = 32'h0;
    case (conf_off)
      CONF_LED:    conf_rdata = {16'h0, led};
      CONF_NUM:    conf_rdata = num_data;
      CONF_SWITCH: conf_rdata = {24'h0, sw_sync};
      CONF_TIMER:  conf_rdata = timer_q;
      default:     conf_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta      <= 8'h0;
      sw_sync      <= 8'h0;
      timer_q      <= 32'h0;
      led          <= 16'h0;
      num_data     <= 32'h0;
      conf_rdata_q <= 32'h0;
      // Selecting the cleared conf register is what makes rdata read 0 after
      // reset, since the RAM's own output register is not reset.
      rd_sel_q     <= SEL_CONF;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      timer_q <= timer_next;

      if (rd_req) begin
        rd_sel_q <= is_conf ? SEL_CONF : SEL_RAM;
        if (is_conf) conf_rdata_q <= conf_rdata;
      end

      if (wr_req && is_conf) begin
        case (conf_off)
          CONF_LED: begin
            if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
          end
          CONF_NUM: num_data <= merge_lanes(num_data, data_sram_wdata, data_sram_wen);
          default: ;
        endcase
      end
    end
  end

  assign data_sram_rdata = (rd_sel_q == SEL_CONF) ? conf_rdata_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios followed by
// random traffic, all compared against a behavioural model of the port.
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_mem [1024];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [31:0] m_rdata;
  logic [7:0]  m_sw_meta;
  logic [7:0]  m_sw_sync;

  data_sram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .led            (led),
    .num_data       (num_data),
    .switch         (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_word, input logic [31:0] new_word,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = new_word[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] conf_read(input logic [15:0] off);
    case (off)
      16'hf000: return {16'h0, m_led};
      16'hf010: return m_num;
      16'hf020: return {24'h0, m_sw_sync};
      16'he000: return m_timer;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led     = 16'h0;
    m_num     = 32'h0;
    m_timer   = 32'h0;
    m_rdata   = 32'h0;
    m_sw_meta = 8'h0;
    m_sw_sync = 8'h0;
  endtask

  // Advances the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] t_next;
    logic [31:0] x;
    logic        conf;
    logic [15:0] off;
    logic [9:0]  idx;
    if (reset) begin
      model_reset();
      return;
    end
    t_next = m_timer + 32'd1;
    conf   = (data_sram_addr[31:16] == 16'hbfaf);
    off    = {data_sram_addr[15:2], 2'b00};
    idx    = data_sram_addr[11:2];
    if (data_sram_en && data_sram_wen == 4'h0) begin
      m_rdata = conf ? conf_read(off) : m_mem[idx];
    end else if (data_sram_en) begin
      if (!conf) begin
        m_mem[idx] = lanes(m_mem[idx], data_sram_wdata, data_sram_wen);
      end else begin
        case (off)
          16'hf000: begin
            x = lanes({16'h0, m_led}, data_sram_wdata, data_sram_wen & 4'b0011);
            m_led = x[15:0];
          end
          16'hf010: m_num = lanes(m_num, data_sram_wdata, data_sram_wen);
          16'he000: t_next = lanes(t_next, data_sram_wdata, data_sram_wen);
          default: ;
        endcase
      end
    end
    m_timer   = t_next;
    m_sw_sync = m_sw_meta;
    m_sw_meta = switch;
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    data_sram_en    = e;
    data_sram_wen   = w;
    data_sram_addr  = a;
    data_sram_wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ":rdata"}, data_sram_rdata, m_rdata);
    check({tag, ":led"}, {16'h0, led}, {16'h0, m_led});
    check({tag, ":num"}, num_data, m_num);
  endtask

  initial begin
    int          kind;
    logic        e;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;

    reset = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    switch = 8'h0;
    model_reset();

    #2 reset = 1'b1;
    #1;
    check("reset:rdata", data_sram_rdata, 32'h0);
    check("reset:led", {16'h0, led}, 32'h0);
    check("reset:num", num_data, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, "in_reset");
    step(1'b0, 4'h0, 32'h0, 32'h0, "in_reset");
    reset = 1'b0;

    step(1'b1, 4'h0, 32'hbfaf_f000, 32'h0, "led_rd0");
    check("led_rd0_const", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hbfaf_f010, 32'h0, "num_rd0");
    check("num_rd0_const", data_sram_rdata, 32'h0);

    for (int i = 0; i < 1024; i++) step(1'b1, 4'hf, 32'(i) << 2, $urandom, "fill");

    // Partial-lane write merges into the stored word
    step(1'b1, 4'hf,    32'h0000_0100, 32'h1234_5678, "rmw_w1");
    step(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_ab00, "rmw_w2");
    step(1'b1, 4'h0,    32'h0000_0100, 32'h0,         "rmw_rd");
    check("rmw_const", data_sram_rdata, 32'h1234_ab78);

    // Address aliasing above the RAM depth, then rdata holds on idle
    step(1'b1, 4'hf, 32'h0000_1000, 32'hdead_beef, "alias_w");
    step(1'b1, 4'h0, 32'h0000_0000, 32'h0,         "alias_rd");
    check("alias_const", data_sram_rdata, 32'hdead_beef);
    step(1'b0, 4'hf, 32'h0000_0000, 32'h5555_5555, "idle1");
    step(1'b0, 4'h0, 32'hbfaf_f000, 32'h0,         "idle2");
    check("hold_const", data_sram_rdata, 32'hdead_beef);
    step(1'b1, 4'h0, 32'h0000_0000, 32'h0,         "idle_nowrite");
    check("idle_nowrite_const", data_sram_rdata, 32'hdead_beef);

    // LED register keeps only lanes 0-1
    step(1'b1, 4'hf, 32'hbfaf_f000, 32'hffff_a5a5, "led_w");
    check("led_const", {16'h0, led}, 32'h0000_a5a5);
    step(1'b1, 4'h0, 32'hbfaf_f000, 32'h0, "led_rd");
    check("led_rd_const", data_sram_rdata, 32'h0000_a5a5);

    // Switch register is read-only and two flops deep
    step(1'b1, 4'hf, 32'hbfaf_f020, 32'hffff_ffff, "sw_w");
    switch = 8'h3c;
    step(1'b0, 4'h0, 32'h0, 32'h0, "sw_wait1");
    step(1'b0, 4'h0, 32'h0, 32'h0, "sw_wait2");
    step(1'b1, 4'h0, 32'hbfaf_f020, 32'h0, "sw_rd");
    check("sw_const", data_sram_rdata, 32'h0000_003c);

    step(1'b1, 4'b0101, 32'hbfaf_f010, 32'h1122_3344, "num_w");
    check("num_const", num_data, 32'h0022_0044);

    // Timer load and wrap
    step(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe, "tmr_w");
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, "tmr_rd0");
    check("tmr_rd0_const", data_sram_rdata, 32'hffff_fffe);
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, "tmr_rd1");
    check("tmr_rd1_const", data_sram_rdata, 32'hffff_ffff);
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, "tmr_wrap");
    check("tmr_wrap_const", data_sram_rdata, 32'h0000_0000);

    // Asynchronous reset in the middle of a write; the write is dropped
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hf;
    data_sram_addr  = 32'h0000_0100;
    data_sram_wdata = 32'hcafe_f00d;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("midrst:rdata", data_sram_rdata, 32'h0);
    check("midrst:led", {16'h0, led}, 32'h0);
    check("midrst:num", num_data, 32'h0);
    @(posedge clk);
    model_edge();
    #1 reset = 1'b0;
    step(1'b1, 4'h0, 32'hbfaf_1234, 32'h0, "unmapped");
    check("unmapped_const", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, "tmr_after_rst");
    check("tmr_after_rst_const", data_sram_rdata, 32'h0000_0001);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0, "dropped_w");
    check("dropped_w_const", data_sram_rdata, 32'h1234_ab78);

    // Random traffic over RAM and config space
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
      e    = ($urandom_range(0, 5) != 0);
      w    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d    = $urandom;
      kind = $urandom_range(0, 9);
      case (kind)
        6:       a = {16'hbfaf, 16'hf000};
        7:       a = {16'hbfaf, 16'hf010};
        8:       a = ($urandom_range(0, 1) == 0) ? {16'hbfaf, 16'hf020} : {16'hbfaf, 16'he000};
        9:       a = {16'hbfaf, 16'($urandom)};
        default: begin
          a = $urandom;
          if (a[31:16] == 16'hbfaf) a[31:16] = 16'h0000;
        end
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      step(e, w, a, d, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
